// File: rtl/fp16_add_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp16_add_arbiter
// Purpose  : Round-robin sharing of one fixed-latency fp16 adder among N
//            requesters, with a per-requester in-flight limit and tagged
//            result return.
// Revision : 1.0
// ============================================================================
module fp16_add_arbiter #(
  parameter int N       = 4,
  parameter int ADD_LAT = 5,
  parameter int MAX_OUT = 2
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic            en,
  input  logic [N-1:0]    req_valid,
  input  logic [16*N-1:0] req_a,
  input  logic [16*N-1:0] req_b,
  output logic [N-1:0]    req_ready,
  output logic            add_de_in,
  output logic [15:0]     add_a,
  output logic [15:0]     add_b,
  input  logic            add_de_out,
  input  logic [15:0]     add_data,
  output logic [N-1:0]    rsp_valid,
  output logic [15:0]     rsp_data,
  output logic            busy,
  output logic            err
);

  localparam int              c_idw     = (N > 1) ? $clog2(N) : 1;
  localparam int              c_cw      = $clog2(MAX_OUT + 1);
  localparam logic [c_cw-1:0] c_max_out = c_cw'(MAX_OUT);

  logic [c_idw-1:0] r_rr_ptr;
  logic [c_cw-1:0]  r_cnt [N];
  logic             r_de_in;
  logic [15:0]      r_a;
  logic [15:0]      r_b;
  logic [c_idw-1:0] r_issue_id;
  logic [ADD_LAT-1:0] r_sv;
  logic [c_idw-1:0] r_sid [ADD_LAT];
  logic [N-1:0]     r_rsp_valid;
  logic [15:0]      r_rsp_data;
  logic             r_err;

  logic [15:0]      w_a [N];
  logic [15:0]      w_b [N];
  logic [N-1:0]     w_elig;
  logic [N-1:0]     w_grant;
  logic [c_idw-1:0] w_gnt_id;
  logic [c_idw-1:0] w_cand;
  logic [c_idw-1:0] w_rr_next;
  logic             w_accept;
  logic             w_tag_v;
  logic [c_idw-1:0] w_tag_id;
  logic             w_rsp_fire;

  for (genvar gi = 0; gi < N; gi++) begin : g_req
    assign w_a[gi]    = req_a[16*gi +: 16];
    assign w_b[gi]    = req_b[16*gi +: 16];
    assign w_elig[gi] = en & req_valid[gi] & (r_cnt[gi] < c_max_out);
  end

  // First eligible requester at or after the round-robin pointer wins.
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_cand   = '0;
    w_accept = 1'b0;
    for (int k = 0; k < N; k++) begin
      w_cand = c_idw'((int'(r_rr_ptr) + k) % N);
      if (!w_accept && w_elig[w_cand]) begin
        w_accept         = 1'b1;
        w_gnt_id         = w_cand;
        w_grant[w_cand]  = 1'b1;
      end
    end
  end

  assign w_rr_next  = (w_gnt_id == c_idw'(N - 1)) ? '0 : w_gnt_id + 1'b1;
  assign w_tag_v    = r_sv[ADD_LAT-1];
  assign w_tag_id   = r_sid[ADD_LAT-1];
  assign w_rsp_fire = w_tag_v & add_de_out;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rr_ptr   <= '0;
      r_de_in    <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_issue_id <= '0;
    end else begin
      r_de_in <= w_accept;
      if (w_accept) begin
        r_a        <= w_a[w_gnt_id];
        r_b        <= w_b[w_gnt_id];
        r_issue_id <= w_gnt_id;
        r_rr_ptr   <= w_rr_next;
      end
    end
  end

  // Shadow of the adder pipeline: last stage lines up with add_de_out.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_sv <= '0;
      for (int s = 0; s < ADD_LAT; s++) r_sid[s] <= '0;
    end else begin
      r_sv[0]  <= r_de_in;
      r_sid[0] <= r_issue_id;
      for (int s = 1; s < ADD_LAT; s++) begin
        r_sv[s]  <= r_sv[s-1];
        r_sid[s] <= r_sid[s-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
      for (int i = 0; i < N; i++) r_cnt[i] <= '0;
    end else begin
      r_rsp_valid <= w_rsp_fire ? (N'(1) << w_tag_id) : '0;
      if (w_rsp_fire) r_rsp_data <= add_data;
      if (w_tag_v != add_de_out) r_err <= 1'b1;
      // A tag leaving the shadow retires its slot even if the adder dropped it.
      for (int i = 0; i < N; i++) begin
        case ({w_accept && (w_gnt_id == c_idw'(i)), w_tag_v && (w_tag_id == c_idw'(i))})
          2'b10:   r_cnt[i] <= r_cnt[i] + 1'b1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 1'b1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  assign req_ready = w_grant;
  assign add_de_in = r_de_in;
  assign add_a     = r_a;
  assign add_b     = r_b;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign err       = r_err;
  assign busy      = r_de_in | (|r_sv) | (|r_rsp_valid);

endmodule
`default_nettype wire

// File: doc/fp16_add_arbiter.md
Name: fp16_add_arbiter

Overview:
- Shares one pipelined float16 adder (fixed latency, no stall, valid-only `de_in`/`de_out` interface) between N requesters.
- Round-robin arbitration, with a per-requester outstanding-operation limit.
- Tags each issued operation, tracks the tag through a shadow pipeline matched to the adder latency, and steers each result back to its originating requester.
- Sits between the vector/accumulate control logic and the adder instance.

Parameters:
- N, 4, number of requesters (2..8).
- ADD_LAT, 5, clock edges from `add_de_in` high to matching `add_de_out` high.
- MAX_OUT, 2, maximum in-flight operations per requester (1..ADD_LAT+1).

Ports:
- clk  input  1  clock.
- rst_b  input  1  reset, asynchronous, active-low.
- en  input  1  arbitration enable; low blocks new grants, in-flight ops still complete.
- req_valid  input  N  per-requester operation request.
- req_a  input  16*N  operand A, requester i at [16i+15:16i], fp16 (sign 1, exp 5, frac 10).
- req_b  input  16*N  operand B, same packing.
- req_ready  output  N  grant, one-hot or zero; an op is accepted at an edge where req_valid[i] & req_ready[i].
- add_de_in  output  1  adder input valid.
- add_a  output  16  adder operand 1.
- add_b  output  16  adder operand 2.
- add_de_out  input  1  adder output valid.
- add_data  input  16  adder result.
- rsp_valid  output  N  one-cycle pulse, one-hot; result returned to requester i.
- rsp_data  output  16  result, valid only while rsp_valid is nonzero.
- busy  output  1  any op in the shadow pipeline, or rsp_valid nonzero.
- err  output  1  sticky tag/valid mismatch flag.

Behaviour:
- Reset (async, rst_b low): all outputs 0, rr_ptr=0, outstanding counters 0, shadow pipeline cleared, err=0.
- Eligibility: requester i is eligible when req_valid[i]=1, cnt[i]<MAX_OUT and en=1.
- req_ready is combinational from req_valid, cnt, en and rr_ptr. It grants the first eligible index searching i=rr_ptr, rr_ptr+1, … mod N. At most one bit is set.
- On accept of i: rr_ptr<=(i+1) mod N; otherwise rr_ptr holds.
- Issue register: on the accept edge, add_de_in<=1, add_a<=req_a[i], add_b<=req_b[i]. With no accept, add_de_in<=0 and operands hold their last value.
- Shadow pipeline: ADD_LAT stages of {v,id}. Stage 0 loads {add_de_in, id of op currently on add_a/add_b}, aligned so the last stage corresponds to add_de_out.
- Response register: at each edge, rsp_valid<=(last.v & add_de_out) ? onehot(last.id) : 0, and rsp_data<=add_data when a response fires (else hold).
- Latency: accept edge E0 to rsp_valid high after edge E0+ADD_LAT+1 (6 for default). Throughput: 1 op/cycle.
- Counters: cnt[i] increments on accept of i and decrements at the edge where the response for i is registered. Simultaneous increment and decrement leaves it unchanged. The eligibility compare uses the registered cnt, so no same-cycle bypass.
- Mismatch: an edge where last.v != add_de_out sets err=1. err is cleared only by reset. A mismatched add_de_out without a tag produces no rsp and no counter change. A tag without add_de_out still decrements cnt[id] and produces no rsp.
- en falling: no new grants from the next evaluation. In-flight ops drain normally and busy falls after the last rsp.
- Reset mid-operation: in-flight ops are discarded. The adder shares rst_b, so no stale results appear after release.
- Arithmetic: none in this block; results are passed through bit-exact from the adder.

Test Plan:
- Single op: req0 a=0x3C00, b=0x3C00 accepted at edge 0 → rsp_valid=4'b0001, rsp_data=0x4000 after edge 6 for one cycle. busy high from edge 0 through the rsp cycle.
- Fairness: all four req_valid held high with MAX_OUT=ADD_LAT+1 → grant order 0,1,2,3,0,1,… one per cycle. Responses arrive in the same order, each with the correct id, 6 cycles after its grant.
- Outstanding limit: MAX_OUT=2, only req1 valid → accepts at edges 0,1. Stalled until the first response decrements cnt at edge 6. Next accepts at edges 7,8, then 14,15.
- Round-robin skip: req0 and req2 valid, rr_ptr=1 → grant 2, then 0, then 2.
- Enable and reset: drop en with 3 ops in flight → no new grants, 3 responses, then busy=0. Repeat with rst_b pulsed low mid-flight → all outputs 0 immediately and no responses after release.
- Error: force add_de_out=1 with an empty shadow pipeline → err=1 and stays 1, no rsp_valid, counters unchanged.
